// File: rtl/lut_neuron_loader_pkg.sv
// Shared definitions for the runtime-programmable LUT neuron loader.
// Holds the FSM state type and the table geometry derived from the
// default neuron widths.
package lut_neuron_pkg;

    localparam int DEF_IN_BITS  = 6;
    localparam int DEF_OUT_BITS = 2;
    localparam int DEF_CFG_BITS = 8;

    localparam int ENTRIES  = 2 ** DEF_IN_BITS;
    localparam int PACK     = DEF_CFG_BITS / DEF_OUT_BITS;
    localparam int BEATS    = ENTRIES / PACK;
    localparam int PTR_BITS = $clog2(BEATS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        READY = 2'd2
    } state_t;

endpackage

// File: rtl/lut_neuron_loader_if.sv
// Configuration and lookup streams of one LUT neuron position.
//
// Handshake rule for both streams: a beat (cfg_*) or a lookup (in_*) is
// transferred on a rising edge where valid && ready are both high; valid
// may be raised or dropped freely, and ready never depends on a future
// edge. The result stream (out_*) has no ready: out_valid is a one-cycle
// pulse per accepted lookup and the consumer must always take it.
interface lut_neuron_loader_if
    import lut_neuron_pkg::*;
#(
    parameter int IN_BITS  = DEF_IN_BITS,
    parameter int OUT_BITS = DEF_OUT_BITS,
    parameter int CFG_BITS = DEF_CFG_BITS
);
    logic                cfg_start;
    logic                cfg_valid;
    logic [CFG_BITS-1:0] cfg_data;
    logic                cfg_ready;
    logic                cfg_done;
    logic                loaded;
    logic                in_valid;
    logic [IN_BITS-1:0]  in_data;
    logic                in_ready;
    logic                out_valid;
    logic [OUT_BITS-1:0] out_data;

    modport master (
        output cfg_start, cfg_valid, cfg_data, in_valid, in_data,
        input  cfg_ready, cfg_done, loaded, in_ready, out_valid, out_data
    );

    modport slave (
        input  cfg_start, cfg_valid, cfg_data, in_valid, in_data,
        output cfg_ready, cfg_done, loaded, in_ready, out_valid, out_data
    );

endinterface

// File: rtl/lut_neuron_loader_table.sv
// Truth-table storage: PACK entries written per beat, one registered read.
// Kept apart from the FSM so the array maps cleanly onto LUT storage.
module lut_neuron_table #(
    parameter int IN_BITS  = 6,
    parameter int OUT_BITS = 2,
    parameter int CFG_BITS = 8,
    localparam int N_PACK    = CFG_BITS / OUT_BITS,
    localparam int N_ENTRIES = 2 ** IN_BITS,
    localparam int N_PTR     = $clog2(N_ENTRIES / N_PACK)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we,
    input  logic [N_PTR-1:0]    wptr,
    input  logic [CFG_BITS-1:0] wdata,
    input  logic                re,
    input  logic [IN_BITS-1:0]  raddr,
    output logic [OUT_BITS-1:0] rdata
);

    logic [OUT_BITS-1:0] mem [N_ENTRIES];

    // Clear on reset; beat write fans out to PACK consecutive entries;
    // the read register only moves on an accepted lookup so it holds otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_ENTRIES; i++) begin
                mem[i] <= '0;
            end
            rdata <= '0;
        end else begin
            if (we) begin
                for (int j = 0; j < N_PACK; j++) begin
                    mem[IN_BITS'(N_PACK * int'(wptr) + j)] <= wdata[OUT_BITS*j +: OUT_BITS];
                end
            end
            if (re) begin
                rdata <= mem[raddr];
            end
        end
    end

endmodule

// File: rtl/lut_neuron_loader.sv
// Runtime-programmable LUT neuron: loads a truth table over the config
// stream, then serves one-cycle-latency lookups from it.
module lut_neuron_loader
    import lut_neuron_pkg::*;
#(
    parameter int IN_BITS  = DEF_IN_BITS,
    parameter int OUT_BITS = DEF_OUT_BITS,
    parameter int CFG_BITS = DEF_CFG_BITS
) (
    input  logic                clk,
    input  logic                rst,
    lut_neuron_loader_if.slave  bus,
    output state_t              dbg_state
);

    localparam int N_PACK    = CFG_BITS / OUT_BITS;
    localparam int N_BEATS   = (2 ** IN_BITS) / N_PACK;
    localparam int N_PTR     = $clog2(N_BEATS);
    localparam logic [N_PTR-1:0] LAST_BEAT = N_PTR'(N_BEATS - 1);

    state_t             state_q, state_d;
    logic [N_PTR-1:0]   ptr_q, ptr_d;
    logic               done_q, done_d;
    logic               out_valid_q;
    logic               cfg_ready, in_ready, we, re;
    logic [OUT_BITS-1:0] rdata;

    // State, beat pointer, done pulse and result-valid registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            done_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            done_q      <= done_d;
            out_valid_q <= re;
        end
    end

    // Next state and handshakes; cfg_start always wins over a beat or lookup
    // presented in the same cycle.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        done_d    = 1'b0;
        cfg_ready = 1'b0;
        in_ready  = 1'b0;
        we        = 1'b0;
        re        = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.cfg_start) begin
                    state_d = LOAD;
                    ptr_d   = '0;
                end
            end
            LOAD: begin
                cfg_ready = !bus.cfg_start;
                if (bus.cfg_start) begin
                    ptr_d = '0;
                end else if (bus.cfg_valid) begin
                    we = 1'b1;
                    if (ptr_q == LAST_BEAT) begin
                        state_d = READY;
                        done_d  = 1'b1;
                        ptr_d   = '0;
                    end else begin
                        ptr_d = ptr_q + 1'b1;
                    end
                end
            end
            READY: begin
                in_ready = !bus.cfg_start;
                if (bus.cfg_start) begin
                    state_d = LOAD;
                    ptr_d   = '0;
                end else if (bus.in_valid) begin
                    re = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                ptr_d   = '0;
            end
        endcase
    end

    lut_neuron_table #(
        .IN_BITS  (IN_BITS),
        .OUT_BITS (OUT_BITS),
        .CFG_BITS (CFG_BITS)
    ) u_table (
        .clk   (clk),
        .rst   (rst),
        .we    (we),
        .wptr  (ptr_q),
        .wdata (bus.cfg_data),
        .re    (re),
        .raddr (bus.in_data),
        .rdata (rdata)
    );

    // Handshake outputs are held low for the whole time rst is asserted.
    assign bus.cfg_ready = cfg_ready && !rst;
    assign bus.in_ready  = in_ready && !rst;
    assign bus.cfg_done  = done_q;
    assign bus.loaded    = (state_q == READY) && !rst;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = rdata;
    assign dbg_state     = state_q;

endmodule

// File: doc/lut_neuron_loader.md
Name: lut_neuron_loader

Overview:
- Runtime-programmable LUT neuron: the write-side counterpart of the fixed-ROM neuron tables.
- Accepts truth-table contents over a valid/ready configuration stream and stores them in a 2^IN_BITS x OUT_BITS register table.
- Once loaded, serves registered lookups on an input stream.
- Sits between the configuration bus and one neuron position in a layer, so table contents can be updated without resynthesis.

Parameters:
- IN_BITS, 6, neuron input width; table depth ENTRIES = 2**IN_BITS (64).
- OUT_BITS, 2, neuron output width per entry.
- CFG_BITS, 8, config beat width; must be a multiple of OUT_BITS. PACK = CFG_BITS/OUT_BITS entries per beat (4).

Ports:
- clk  input  1  system clock, all logic rising-edge.
- rst  input  1  synchronous active-high reset.
- cfg_start  input  1  pulse: begin (re)load at entry 0.
- cfg_valid  input  1  config beat valid.
- cfg_data  input  CFG_BITS  packed table entries.
- cfg_ready  output  1  config beat accepted when cfg_valid && cfg_ready.
- cfg_done  output  1  one-cycle pulse when the last beat is written.
- loaded  output  1  high while the table is valid for lookup.
- in_valid  input  1  lookup request.
- in_data  input  IN_BITS  lookup address (neuron input vector).
- in_ready  output  1  lookup accepted when in_valid && in_ready.
- out_valid  output  1  lookup result valid (single-cycle pulse per accepted lookup).
- out_data  output  OUT_BITS  table[in_data].

Behaviour:
- Single clock. Reset is synchronous and active-high; clock port is clk, reset port is rst.
- Values while rst is high:
  - table all zeros
  - state IDLE, write pointer 0
  - cfg_ready 0, cfg_done 0, loaded 0, in_ready 0, out_valid 0, out_data 0
- State IDLE:
  - cfg_ready=0, in_ready=0.
  - cfg_start -> LOAD, pointer 0.
- State LOAD:
  - cfg_ready=1.
  - Beat accept at pointer k writes cfg_data[OUT_BITS*j +: OUT_BITS] into entry PACK*k+j, for j=0..PACK-1; then k increments.
  - cfg_valid gaps hold k.
  - Accept at k = ENTRIES/PACK-1 (15): write, then next cycle state READY, loaded=1, cfg_done=1 for exactly one cycle.
  - cfg_start in LOAD restarts at k=0; a beat presented that same cycle is not accepted (cfg_ready forced 0 while cfg_start=1).
  - Partial loads never set loaded. Entries written before a restart keep their values until overwritten.
- State READY:
  - in_ready = !cfg_start (combinational).
  - Accepted lookup: out_data <= table[in_data], out_valid <= 1 on the next edge (latency 1).
  - Otherwise out_valid <= 0 and out_data holds its last value.
  - Back-to-back lookups give one result per cycle.
  - There is no output backpressure; the consumer must always sink results.
- cfg_start in READY:
  - Takes priority over a simultaneous in_valid; that lookup is not accepted.
  - Next cycle: loaded=0, state LOAD.
  - A lookup accepted in the previous cycle still produces its out_valid (the table read completes before overwrite).
- rst at any time, including mid-load or mid-lookup, returns to reset values within the same edge. The table is cleared, and the next lookup requires a full reload.
- Pointer width is clog2(ENTRIES/PACK). No wrap-around is possible because LOAD exits on the final beat.
- cfg_valid in IDLE/READY is ignored (cfg_ready=0). in_valid outside READY is ignored.

Decomposition:
- Shared package lut_neuron_pkg:
  - state enum {IDLE, LOAD, READY}
  - localparams ENTRIES, PACK, PTR_BITS derived from the parameters
- One sub-module: lut_neuron_table.
  - Register array with a PACK-wide write port and a single synchronous read port.
  - Keeps distributed/LUT-RAM inference isolated from the FSM.

Test Plan:
- Reset, then cfg_start plus 16 beats of cfg_data=8'hE4 (no gaps) -> cfg_done pulses once the cycle after beat 15; loaded=1; lookup in_data=6'd37 gives out_data=2'b01 one cycle later; lookup 6'd63 gives 2'b11.
- Load with cfg_valid toggling every other cycle, beat k = {4{k[1:0]}} -> 16 accepts; table[4k+j]=k[1:0]; lookups 0..63 streamed back-to-back each return in 1 cycle with one out_valid per request.
- cfg_start after 7 beats, then 16 beats of 8'h00 -> loaded stays 0 until the 16th accept; all lookups return 2'b00.
- In READY, cfg_start asserted together with in_valid=1, in_data=5 -> in_ready=0, no out_valid next cycle, loaded=0 next cycle.
- rst asserted mid-load (beat 9) -> next cycle cfg_ready=0, loaded=0; after rst drops, in_valid=1 gives in_ready=0 and no out_valid.
- Lookups attempted in IDLE and LOAD -> in_ready=0 and out_valid stays 0 throughout.
